mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified memory of the multicycle CPU between two requesters: port 0 is the CPU controller (instruction fetch and operand/result traffic), port 1 is the program loader/debug port. It grants one access at a time with round-robin fairness, latches the request, sequences a fixed-latency memory access, and returns read data with a one-cycle acknowledge pulse. It sits between the controller/datapath memory mux and the memory array.

## Interface
Parameters:
- AW, 5, address width
- DW, 8, data width
- WAIT, 2, memory access cycles per transfer (legal range 1..15)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- r0_req / r1_req  in  1  access request, held high until matching ack
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  AW  word address
- r0_wdata / r1_wdata  in  DW  write data
- r0_ack / r1_ack  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DW  read data, valid from ack cycle until next ack on that port
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, valid WAIT cycles after address presented
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if neither req, stay. If exactly one req, grant it. If both, grant the port named by priority pointer `pri` (0 or 1). On grant: latch grant id, we, addr, wdata into internal registers; load counter with WAIT-1; go ACCESS.
- ACCESS: mem_addr/mem_wdata driven from latched registers. mem_we = latched we, asserted in the first ACCESS cycle only. Counter decrements each cycle; at counter == 0 capture mem_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged) and go RESP.
- RESP: assert ack of granted port for exactly this cycle; set `pri` to the other port; go IDLE.
- Requests are sampled only in IDLE; req changes during ACCESS/RESP are ignored and the latched access completes and is acked regardless.
- A requester still holding req in the cycle after its ack is treated as a new request.
- mem_addr/mem_wdata hold the last latched values outside ACCESS; mem_we is 0 outside the first ACCESS cycle.
- Counter width 4 bits; no wrap possible within legal WAIT.

## Timing
- Reset (async, immediate): state IDLE, pri = 0, counter 0, all ack 0, both rdata 0, mem_addr 0, mem_wdata 0, mem_we 0, busy 0. Reset mid-ACCESS aborts: no ack issued, mem_we drops immediately.
- req high in IDLE during cycle 0 -> ACCESS in cycles 1..WAIT -> mem_rdata sampled at end of cycle WAIT -> ack in cycle WAIT+1 -> IDLE in cycle WAIT+2.
- Latency req-to-ack: WAIT+1 cycles. Throughput: one access per WAIT+2 cycles (one mandatory IDLE cycle between accesses).
- Losing requester waits; it is granted in the IDLE cycle immediately after the winner's RESP if still requesting.
- Outputs ack, mem_we, busy are registered/state-decoded; no combinational path from any req to any output.

## Test plan
- Reset, WAIT=2: r0 read addr 5 with memory word 5 = 8'hA5, req in cycle 0 -> mem_we never high, r0_ack only in cycle 3, r0_rdata = 8'hA5 from cycle 3, r1_ack stays 0.
- r1 write addr 3 data 8'h3C -> mem_we high in cycle 1 only with mem_addr=3, mem_wdata=8'h3C; r1_ack cycle 3; r1_rdata unchanged (0).
- Both req in same IDLE cycle after reset -> r0 granted first (ack cycle 3), r1 granted cycle 4 (ack cycle 7); repeat with both held -> alternates 0,1,0,1.
- r0 drops req during ACCESS -> access still completes, r0_ack pulses once; no second access started.
- rst asserted mid-ACCESS of a write -> mem_we, busy, acks 0 immediately; after release state IDLE, pri=0, no ack for aborted access.
- WAIT=1 and WAIT=15 builds: ack latency exactly 2 and 16 cycles respectively.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter for the shared unified memory
// A grant latches one access, runs it for WAIT cycles, then pulses the winner's ack.
module mem_port_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_t     state;
  logic       pri;
  logic       gnt;
  logic       lwe;
  logic [3:0] cnt;
  logic       pick;

  // Contention goes to the pointer; a lone requester always wins.
  assign pick = (r0_req && r1_req) ? pri : r1_req;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pri       <= 1'b0;
      gnt       <= 1'b0;
      lwe       <= 1'b0;
      cnt       <= 4'd0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            gnt       <= pick;
            lwe       <= pick ? r1_we : r0_we;
            mem_we    <= pick ? r1_we : r0_we;
            mem_addr  <= pick ? r1_addr : r0_addr;
            mem_wdata <= pick ? r1_wdata : r0_wdata;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lwe) begin
              if (gnt) r1_rdata <= mem_rdata;
              else     r0_rdata <= mem_rdata;
            end
            if (gnt) r1_ack <= 1'b1;
            else     r0_ack <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          pri   <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Memory word at address a reads as {~a[3:0], a[3:0]}; address 5 gives 8'hA5.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [4:0] r0_addr = '0, r1_addr = '0;
  logic [7:0] r0_wdata = '0, r1_wdata = '0;
  logic       r0_ack, r1_ack, mem_we, busy;
  logic [7:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  logic       a_req = 1'b0, b_req = 1'b0;
  logic       a_ack, a_ack1, a_we, a_busy, b_ack, b_ack1, b_we, b_busy;
  logic [7:0] a_rd0, a_rd1, a_wd, a_mrd, b_rd0, b_rd1, b_wd, b_mrd;
  logic [4:0] a_ma, b_ma;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = {~mem_addr[3:0], mem_addr[3:0]};
  assign a_mrd     = {~a_ma[3:0], a_ma[3:0]};
  assign b_mrd     = {~b_ma[3:0], b_ma[3:0]};

  mem_port_arbiter #(.AW(5), .DW(8), .WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(5), .DW(8), .WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .r0_req(a_req), .r0_we(1'b0), .r0_addr(5'd9), .r0_wdata(8'h00),
    .r0_ack(a_ack), .r0_rdata(a_rd0),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr(5'd0), .r1_wdata(8'h00),
    .r1_ack(a_ack1), .r1_rdata(a_rd1),
    .mem_addr(a_ma), .mem_wdata(a_wd), .mem_we(a_we),
    .mem_rdata(a_mrd), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(5), .DW(8), .WAIT(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .r0_req(b_req), .r0_we(1'b0), .r0_addr(5'd12), .r0_wdata(8'h00),
    .r0_ack(b_ack), .r0_rdata(b_rd0),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr(5'd0), .r1_wdata(8'h00),
    .r1_ack(b_ack1), .r1_rdata(b_rd1),
    .mem_addr(b_ma), .mem_wdata(b_wd), .mem_we(b_we),
    .mem_rdata(b_mrd), .busy(b_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({r0_ack, r1_ack, mem_we, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl got %b want 0000", {r0_ack, r1_ack, mem_we, busy});
    end
    checks++;
    if ({r0_rdata, r1_rdata, mem_addr, mem_wdata} !== 29'd0) begin
      errors++; $display("FAIL reset_data got r0=%h r1=%h a=%h wd=%h want 0", r0_rdata, r1_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 5'd5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL read_we cyc %0d got %b want 0", k, mem_we); end
      checks++;
      if (r0_ack !== (k == 3) || r1_ack !== 1'b0) begin
        errors++; $display("FAIL read_ack cyc %0d got %b%b want %b0", k, r0_ack, r1_ack, k == 3);
      end
      checks++;
      if (busy !== (k <= 3)) begin errors++; $display("FAIL read_busy cyc %0d got %b want %b", k, busy, k <= 3); end
      if (k >= 3) begin
        checks++;
        if (r0_rdata !== 8'hA5) begin errors++; $display("FAIL read_data cyc %0d got %h want a5", k, r0_rdata); end
      end
      if (k == 3) r0_req = 1'b0;
    end
  endtask

  task automatic test_write();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 5'd3; r1_wdata = 8'h3C;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== (k == 1)) begin errors++; $display("FAIL write_we cyc %0d got %b want %b", k, mem_we, k == 1); end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 5'd3 || mem_wdata !== 8'h3C) begin
          errors++; $display("FAIL write_bus got a=%h d=%h want a=03 d=3c", mem_addr, mem_wdata);
        end
      end
      checks++;
      if (r1_ack !== (k == 3) || r0_ack !== 1'b0) begin
        errors++; $display("FAIL write_ack cyc %0d got %b%b want 0%b", k, r0_ack, r1_ack, k == 3);
      end
      if (k == 3) begin
        r1_req = 1'b0;
        checks++;
        if (r1_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata got %h want 00", r1_rdata); end
      end
    end
    r1_we = 1'b0;
  endtask

  task automatic test_both();
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 5'd5;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 5'd3;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      checks++;
      if (r0_ack !== (k == 3 || k == 11) || r1_ack !== (k == 7 || k == 15)) begin
        errors++; $display("FAIL both_ack cyc %0d got %b%b want %b%b", k, r0_ack, r1_ack,
                           k == 3 || k == 11, k == 7 || k == 15);
      end
      if (k == 7) begin
        checks++;
        if (r1_rdata !== 8'hC3) begin errors++; $display("FAIL both_r1data got %h want c3", r1_rdata); end
      end
      if (k == 3) begin
        checks++;
        if (r0_rdata !== 8'hA5) begin errors++; $display("FAIL both_r0data got %h want a5", r0_rdata); end
      end
      if (k >= 16) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL both_idle cyc %0d got busy %b want 0", k, busy); end
      end
      if (k == 15) begin r0_req = 1'b0; r1_req = 1'b0; end
    end
  endtask

  task automatic test_drop();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 5'd7;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) r0_req = 1'b0;
      checks++;
      if (r0_ack !== (k == 3) || busy !== (k <= 3)) begin
        errors++; $display("FAIL drop cyc %0d got ack %b busy %b want %b %b", k, r0_ack, busy, k == 3, k <= 3);
      end
      if (k == 3) begin
        checks++;
        if (r0_rdata !== 8'h87) begin errors++; $display("FAIL drop_data got %h want 87", r0_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 5'd2; r1_wdata = 8'h5E;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_we_pre got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, busy, r0_ack, r1_ack} !== 4'b0000) begin
      errors++; $display("FAIL mid_abort got %b want 0000", {mem_we, busy, r0_ack, r1_ack});
    end
    @(negedge clk);
    r1_req = 1'b0; r1_we = 1'b0; rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_we, busy, r0_ack, r1_ack} !== 4'b0000) begin
        errors++; $display("FAIL mid_after cyc %0d got %b want 0000", k, {mem_we, busy, r0_ack, r1_ack});
      end
    end
    r0_req = 1'b1; r0_addr = 5'd5; r1_req = 1'b1; r1_addr = 5'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (r0_ack !== (k == 3) || r1_ack !== 1'b0) begin
        errors++; $display("FAIL mid_pri cyc %0d got %b%b want %b0", k, r0_ack, r1_ack, k == 3);
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic test_wait_builds();
    int lat1 = -1, lat15 = -1, n1 = 0, n15 = 0;
    do_reset();
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a_ack) begin n1++; if (lat1 < 0) lat1 = k; a_req = 1'b0; end
      if (b_ack) begin n15++; if (lat15 < 0) lat15 = k; b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (lat1 != 2 || n1 != 1) begin errors++; $display("FAIL wait1_latency got %0d x%0d want 2 x1", lat1, n1); end
    checks++;
    if (lat15 != 16 || n15 != 1) begin errors++; $display("FAIL wait15_latency got %0d x%0d want 16 x1", lat15, n15); end
    checks++;
    if (a_rd0 !== 8'h69 || b_rd0 !== 8'h3C) begin
      errors++; $display("FAIL wait_data got %h %h want 69 3c", a_rd0, b_rd0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_both();
    test_drop();
    test_reset_mid();
    test_wait_builds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
